// File: rtl/arinc429_tx.sv
// ARINC 429 line transmitter: serializes 32-bit words as return-to-zero bipolar
// HI/LO/NULL line states, with optional odd parity in bit 31 and an inter-word NULL gap.
module arinc429_tx #(
  parameter int CLK_DIV   = 250,
  parameter int GAP_BITS  = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx_hi,
  output logic        tx_lo,
  output logic        busy,
  output logic        word_done
);

  localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_HALVES = 2 * GAP_BITS;
  localparam int GW         = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

  typedef enum logic [1:0] {IDLE, HALF_ON, HALF_NULL, GAP} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] div_reg, div_next;
  logic [4:0]    bit_reg, bit_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [31:0]   shift_reg, shift_next;
  logic          tx_hi_next, tx_lo_next, busy_next, done_next;
  logic          half_end, xfer;
  logic [31:0]   load_word;

  assign s_ready   = (state_reg == IDLE) & en & ~rst;
  assign xfer      = s_valid & s_ready;
  assign half_end  = (div_reg == DW'(CLK_DIV - 1));
  assign load_word = PARITY_EN ? {~^s_data[30:0], s_data[30:0]} : s_data;

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    gap_next   = gap_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          state_next = HALF_ON;
          shift_next = load_word;
          div_next   = '0;
          bit_next   = '0;
        end
      end
      HALF_ON: begin
        if (half_end) begin
          div_next   = '0;
          state_next = HALF_NULL;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      HALF_NULL: begin
        if (half_end) begin
          div_next = '0;
          if (bit_reg != 5'd31) begin
            shift_next = {1'b0, shift_reg[31:1]};
            bit_next   = bit_reg + 5'd1;
            state_next = HALF_ON;
          end else begin
            gap_next   = '0;
            done_next  = 1'b1;
            state_next = GAP;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      GAP: begin
        if (half_end) begin
          div_next = '0;
          if (gap_reg == GW'(GAP_HALVES - 1)) state_next = IDLE;
          else gap_next = gap_reg + 1'b1;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Line outputs are registered from the next state so bit 0 drives right after the transfer edge.
    tx_hi_next = (state_next == HALF_ON) &  shift_next[0];
    tx_lo_next = (state_next == HALF_ON) & ~shift_next[0];
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
      shift_reg <= '0;
      tx_hi     <= 1'b0;
      tx_lo     <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      gap_reg   <= gap_next;
      shift_reg <= shift_next;
      tx_hi     <= tx_hi_next;
      tx_lo     <= tx_lo_next;
      busy      <= busy_next;
      word_done <= done_next;
    end
  end

endmodule

// File: tb/tb_arinc429_tx.sv
// Self-checking bench for arinc429_tx: a timeline model (position within word/gap since
// each transfer) predicts every output of a parity and a non-parity instance each cycle.
module tb_arinc429_tx;
  localparam int CLK_DIV  = 4;
  localparam int GAP_BITS = 4;
  localparam int HB       = 2 * CLK_DIV;
  localparam int WORD_CYC = 64 * CLK_DIV;
  localparam int BUSY_CYC = WORD_CYC + 2 * GAP_BITS * CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, s_valid;
  logic [31:0] s_data;
  logic        s_ready, tx_hi, tx_lo, busy, word_done;
  logic        s_ready_np, tx_hi_np, tx_lo_np, busy_np, word_done_np;

  arinc429_tx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_hi(tx_hi), .tx_lo(tx_lo), .busy(busy), .word_done(word_done));

  arinc429_tx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_np),
    .tx_hi(tx_hi_np), .tx_lo(tx_lo_np), .busy(busy_np), .word_done(word_done_np));

  // Model: m_k = cycles since the transfer edge (1 = first cycle bit 0 is on the line)
  bit          m_active;
  int          m_k;
  logic [31:0] m_word_p, m_word_np;
  int          cyc, xfer_cyc;
  int          vectors, miscompares;
  int          dut_xfers[$];
  int          wd_cycles[$];
  int          pin_cyc, rdy_ret;
  bit          rdy_watch;
  logic        pin_hi, pin_lo_np;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_outputs();
    logic e_hi, e_lo, e_hi_np, e_lo_np, e_busy, e_done;
    int j, idx;
    e_hi = 0; e_lo = 0; e_hi_np = 0; e_lo_np = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      e_busy = 1;
      if (m_k <= WORD_CYC) begin
        j   = m_k - 1;
        idx = j / HB;
        if ((j % HB) < CLK_DIV) begin
          e_hi    = m_word_p[idx];  e_lo    = ~m_word_p[idx];
          e_hi_np = m_word_np[idx]; e_lo_np = ~m_word_np[idx];
        end
      end
      e_done = (m_k == WORD_CYC + 1);
    end
    chk("tx_hi", tx_hi, e_hi);
    chk("tx_lo", tx_lo, e_lo);
    chk("busy", busy, e_busy);
    chk("word_done", word_done, e_done);
    chk("tx_hi_np", tx_hi_np, e_hi_np);
    chk("tx_lo_np", tx_lo_np, e_lo_np);
    chk("busy_np", busy_np, e_busy);
    chk("word_done_np", word_done_np, e_done);
    chk("hi_lo_overlap", {30'd0, tx_hi & tx_lo, tx_hi_np & tx_lo_np}, 32'd0);
    if (word_done === 1'b1) wd_cycles.push_back(cyc);
    if (cyc == pin_cyc) begin
      pin_hi    = tx_hi;
      pin_lo_np = tx_lo_np;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [31:0] d);
    logic exp_ready;
    @(negedge clk);
    cyc++;
    compare_outputs();
    rst = r; en = e; s_valid = v; s_data = d;
    #1;
    exp_ready = !m_active && e && !r;
    chk("s_ready", s_ready, exp_ready);
    chk("s_ready_np", s_ready_np, exp_ready);
    if (s_valid && s_ready) dut_xfers.push_back(cyc);
    if (rdy_watch && s_ready === 1'b1) begin
      rdy_ret   = cyc;
      rdy_watch = 0;
    end
    if (r) m_active = 0;
    else if (!m_active) begin
      if (v && e) begin
        m_active  = 1;
        m_k       = 1;
        m_word_p  = {~^d[30:0], d[30:0]};
        m_word_np = d;
        xfer_cyc  = cyc;
      end
    end else begin
      m_k++;
      if (m_k > BUSY_CYC) m_active = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, $urandom);
  endtask

  initial begin
    int t0, en_rise, guard;
    rst = 1; en = 0; s_valid = 0; s_data = 0;
    m_active = 0; m_k = 0; cyc = 0; vectors = 0; miscompares = 0;
    pin_cyc = -1; rdy_watch = 0; rdy_ret = -1; pin_hi = 0; pin_lo_np = 0;

    // Reset, then idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
    idle(5);

    // Word 1: latency of word_done and return of s_ready
    wd_cycles.delete();
    step(1'b0, 1'b1, 1'b1, 32'h0000_0001);
    t0 = xfer_cyc;
    rdy_watch = 1;
    idle(300);
    chk("word_done_latency", (wd_cycles.size() > 0) ? wd_cycles[0] - t0 : -1, 257);
    chk("ready_return", rdy_ret - t0, 289);

    // Word 0: parity forces bit 31 HI; unparitied instance sends it LO
    step(1'b0, 1'b1, 1'b1, 32'h0000_0000);
    pin_cyc = xfer_cyc + 249;
    idle(300);
    chk("parity_bit31_hi", pin_hi, 1);
    chk("noparity_bit31_lo", pin_lo_np, 1);

    // Back-to-back with s_valid held and data churning
    dut_xfers.delete();
    for (int i = 0; i < 600; i++) step(1'b0, 1'b1, 1'b1, $urandom);
    chk("b2b_period", (dut_xfers.size() > 1) ? dut_xfers[1] - dut_xfers[0] : -1, 289);
    idle(300);

    // en dropped at bit 10, held off past the end of the gap, then restored
    step(1'b0, 1'b1, 1'b1, $urandom);
    idle(10 * HB);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    dut_xfers.delete();
    step(1'b0, 1'b1, 1'b1, $urandom);
    en_rise = cyc;
    chk("en_restore_xfer", (dut_xfers.size() > 0) ? dut_xfers[0] - en_rise : -1, 0);
    idle(300);

    // Reset during bit 15 ON half aborts the word
    step(1'b0, 1'b1, 1'b1, 32'hA5A5_5A5A);
    guard = 0;
    while (m_k != 15 * HB + 1 && guard < 400) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      guard++;
    end
    chk("reach_bit15", m_k, 15 * HB + 1);
    wd_cycles.delete();
    step(1'b1, 1'b1, 1'b0, 32'd0);
    idle(200);
    chk("abort_no_done", wd_cycles.size(), 0);
    step(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    idle(300);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) != 0), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arinc429_tx.md
Name: arinc429_tx

Overview:
ARINC 429 line transmitter, the outbound counterpart of the receive-side input synchronizer.
- Accepts 32-bit words over a valid/ready handshake.
- Optionally inserts odd parity into bit 31.
- Serializes each word as return-to-zero bipolar HI/LO/NULL line states for the external line driver.
- Enforces the minimum inter-word NULL gap.

Parameters:
CLK_DIV, 250, clocks per half-bit (bit period = 2*CLK_DIV; 250 gives 100 kbps at 50 MHz)
GAP_BITS, 4, NULL bit-times inserted after every word (minimum 1)
PARITY_EN, 1, 1 = bit 31 replaced by odd parity over bits 30:0; 0 = bit 31 sent as supplied

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  transmit enable; gates acceptance of new words only
s_data  in  32  word to send; bit 0 is transmitted first (caller orders label bits)
s_valid  in  1  s_data valid
s_ready  out  1  block can accept a word this cycle
tx_hi  out  1  line driver HI leg (1 = drive positive)
tx_lo  out  1  line driver LO leg (1 = drive negative)
busy  out  1  word or gap in progress
word_done  out  1  one-cycle pulse at end of last bit of a word

Behaviour:
- Reset (rst=1 at clk edge) outputs:
  - tx_hi=0, tx_lo=0, busy=0, word_done=0, s_ready=0 during reset.
  - State IDLE, all counters 0.
  - A reset mid-word aborts the word; NULL appears on the line at the next edge.
- All outputs are registered. tx_hi and tx_lo are never both 1.
- Handshake:
  - s_ready = (state==IDLE) & en & ~rst.
  - Transfer occurs when s_valid & s_ready at a clk edge.
  - s_data is latched into a shift register at that edge.
  - If PARITY_EN=1, the latched bit 31 = ~^s_data[30:0] (total number of ones is odd).
- FSM states: IDLE, HALF_ON, HALF_NULL, GAP.
  - IDLE -> HALF_ON on transfer. busy=1 from the next cycle.
  - HALF_ON, lasting CLK_DIV cycles: tx_hi=cur_bit, tx_lo=~cur_bit.
  - HALF_NULL, lasting CLK_DIV cycles: tx_hi=tx_lo=0.
    - At its end, if bit_cnt<31: shift the register, bit_cnt++, go to HALF_ON.
    - Else: pulse word_done and go to GAP.
  - GAP, lasting GAP_BITS*2*CLK_DIV cycles: NULL on the line. Then go to IDLE with busy=0.
- Latency and timing:
  - Transfer at edge N: tx_hi/tx_lo show bit 0 from edge N+1.
  - Word occupies exactly 64*CLK_DIV cycles on the line, then the gap.
  - word_done is asserted in the cycle the FSM enters GAP.
- Back-to-back words: IDLE lasts at least 1 cycle.
  - Minimum word-to-word period is (64+2*GAP_BITS)*CLK_DIV+1 cycles.
- Divider counter runs 0..CLK_DIV-1 and wraps at each half-bit boundary. bit_cnt is 5 bits, 0..31.
- en deasserted mid-word or mid-gap: the current word and gap complete unchanged; no new transfer until en=1.
- s_valid while not ready: ignored. s_data changes while busy have no effect.

Test Plan:
- Reset, then idle with CLK_DIV=4, GAP_BITS=4 -> tx_hi=tx_lo=0, s_ready=1 when en=1, busy=0.
- Send 32'h0000_0001, PARITY_EN=1:
  - Transfer at edge N -> tx_hi=1 over cycles N+1..N+4, NULL over N+5..N+8.
  - Bits 1..30 show tx_lo=1 in each ON half.
  - Bit 31 = 0 (already odd) -> tx_lo=1.
  - word_done at N+257; s_ready returns at N+289.
- Send 32'h0000_0000, PARITY_EN=1 -> bit 31 transmitted as HI (tx_hi=1 during cycles N+249..N+252). Same word with PARITY_EN=0 -> bit 31 LO.
- Hold s_valid=1 with two words -> second transfer exactly 289 cycles after the first. s_ready stays low throughout the word and gap.
- Drop en at bit 10 of a word -> word and gap finish identically. s_ready stays 0 until en=1, then transfer occurs on the first IDLE cycle.
- Assert rst at bit 15 HALF_ON -> next edge tx_hi=tx_lo=0, busy=0, word_done never pulses. After rst release a new word is sent from bit 0.
- Check across all tests: no cycle has tx_hi&tx_lo=1.
